// File: rtl/inverse_interpolate_pkg.sv
// Shared definitions for the inverse-interpolation block: default width,
// FSM encoding and the derived datapath widths.
package inverse_interpolate_pkg;

  localparam int W_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIFF,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  // Difference width (W+1) and product/quotient width (2W+1).
  function automatic int wp1(input int w);
    return w + 1;
  endfunction

  function automatic int w2p1(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/inverse_interpolate_if.sv
// Request/result bundle for inverse_interpolate.
interface inverse_interpolate_if
  import inverse_interpolate_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         start;
  logic [W-1:0] y;
  logic [W-1:0] x0;
  logic [W-1:0] y0;
  logic [W-1:0] x1;
  logic [W-1:0] y1;
  logic         busy;
  logic         done;
  logic [W-1:0] x;
  logic         err;
  logic         sat;

  modport master (output start, y, x0, y0, x1, y1,
                  input  busy, done, x, err, sat);
  modport slave  (input  start, y, x0, y0, x1, y1,
                  output busy, done, x, err, sat);
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, NW cycles per
// operation; remainder is kept internally and not exported.
module seq_divider #(
  parameter int NW = 21,
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [NW-1:0] quotient_o
);
  localparam int CW = $clog2(NW + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW:0]   rem_sh;
  logic [DW-1:0] trial;
  logic          fits;

  assign rem_sh = {rem_q, quo_q[NW-1]};
  assign fits   = rem_sh >= {1'b0, dvs_q};
  // Result is below 2^DW whenever fits is set, so the modulo subtract is exact.
  assign trial  = rem_sh[DW-1:0] - dvs_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (start_i && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = CW'(NW);
      quo_d  = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      quo_d = {quo_q[NW-2:0], fits};
      rem_d = fits ? trial : rem_sh[DW-1:0];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CW'(1));
  assign quotient_o = quo_q;

endmodule

// File: rtl/inverse_interpolate.sv
// Inverse linear interpolation x = x0 + (y-y0)*(x1-x0)/(y1-y0), sequential
// multiply-then-divide with clamping to the unsigned W-bit range.
//   state  | meaning
//   IDLE   | wait for start, latch operands
//   DIFF   | form dy, dx, den; den==0 short-circuits to FIX
//   MUL    | p = dy*dx
//   DIV    | |p| / |den| in seq_divider
//   FIX    | sign, add x0, clamp, pulse done
module inverse_interpolate
  import inverse_interpolate_pkg::*;
#(
  parameter int W = W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  inverse_interpolate_if.slave bus
);
  localparam int WD = wp1(W);
  localparam int WM = w2p1(W);
  localparam int WQ = WM + 2;

  state_t               state_q, state_d;
  logic [W-1:0]         y_q, y_d, x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic signed [WD-1:0] dy_q, dy_d, dx_q, dx_d, den_q, den_d;
  logic signed [WM-1:0] p_q, p_d;
  logic                 neg_q, neg_d, zero_q, zero_d;
  logic [W-1:0]         x_q, x_d;
  logic                 err_q, err_d, sat_q, sat_d, done_q, done_d;

  logic signed [WD-1:0] dy_c, dx_c, den_c;
  logic signed [WM:0]   prod_c;
  logic [WM-1:0]        abs_p;
  logic [WD-1:0]        abs_den;
  logic signed [WQ-1:0] q_mag, q_c, sum_c;
  logic                 div_start, div_busy, div_done;
  logic [WM-1:0]        div_quo;

  assign dy_c    = $signed({1'b0, y_q})  - $signed({1'b0, y0_q});
  assign dx_c    = $signed({1'b0, x1_q}) - $signed({1'b0, x0_q});
  assign den_c   = $signed({1'b0, y1_q}) - $signed({1'b0, y0_q});
  assign prod_c  = dy_q * dx_q;
  assign abs_p   = p_q[WM-1]   ? $unsigned(-p_q)   : $unsigned(p_q);
  assign abs_den = den_q[WD-1] ? $unsigned(-den_q) : $unsigned(den_q);
  assign q_mag   = $signed({2'b00, div_quo});
  assign q_c     = neg_q ? -q_mag : q_mag;
  assign sum_c   = q_c + $signed({{(WQ-W){1'b0}}, x0_q});

  seq_divider #(.NW(WM), .DW(WD)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (abs_p),
    .divisor_i  (abs_den),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    dy_d      = dy_q;
    dx_d      = dx_q;
    den_d     = den_q;
    p_d       = p_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    x_d       = x_q;
    err_d     = err_q;
    sat_d     = sat_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The done cycle is still IDLE; a start there must not launch.
        if (bus.start && !done_q) begin
          y_d     = bus.y;
          x0_d    = bus.x0;
          y0_d    = bus.y0;
          x1_d    = bus.x1;
          y1_d    = bus.y1;
          state_d = S_DIFF;
        end
      end
      S_DIFF: begin
        dy_d    = dy_c;
        dx_d    = dx_c;
        den_d   = den_c;
        zero_d  = (den_c == '0);
        state_d = (den_c == '0) ? S_FIX : S_MUL;
      end
      S_MUL: begin
        p_d     = prod_c[WM-1:0];
        neg_d   = prod_c[WM-1] ^ den_q[WD-1];
        state_d = S_DIV;
      end
      S_DIV: begin
        div_start = !div_busy;
        if (div_done) state_d = S_FIX;
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        err_d   = 1'b0;
        sat_d   = 1'b0;
        if (zero_q) begin
          x_d   = x0_q;
          err_d = 1'b1;
        end else if (sum_c[WQ-1]) begin
          x_d   = '0;
          sat_d = 1'b1;
        end else if (|sum_c[WQ-2:W]) begin
          x_d   = '1;
          sat_d = 1'b1;
        end else begin
          x_d   = sum_c[W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      dy_q    <= '0;
      dx_q    <= '0;
      den_q   <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      x_q     <= '0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      dy_q    <= dy_d;
      dx_q    <= dx_d;
      den_q   <= den_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      x_q     <= x_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE) || done_q;
  assign bus.done = done_q;
  assign bus.x    = x_q;
  assign bus.err  = err_q;
  assign bus.sat  = sat_q;

endmodule
